// File: rtl/lb_arbiter.sv
//==============================================================================
// lb_arbiter : round-robin two-master arbiter for the local-bus target,
//              bounded hold per owner, read data routed by an owner tag pipe.
// Optional: define LB_ARBITER_STATS_EN for transfer/contention counters.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lb_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int READ_LAT = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic          lb_clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_rd,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_grant,
  output logic          m0_rd_valid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rd,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_grant,
  output logic          m1_rd_valid,
  output logic [DW-1:0] m1_rdata,
  output logic          lb_strobe,
  output logic          lb_rd,
  output logic          lb_write,
  output logic [AW-1:0] lb_addr,
  output logic [DW-1:0] lb_data_out,
`ifdef LB_ARBITER_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   m0_xfer_cnt,
  output logic [15:0]   m1_xfer_cnt,
  output logic [15:0]   contend_cnt,
`endif
  input  logic [DW-1:0] lb_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t        state;
  logic          last_owner;
  logic [7:0]    hold_cnt;
  logic          lb_owner;
  logic [READ_LAT-1:0] tag_v;
  logic [READ_LAT-1:0] tag_o;

  logic       acc0, acc1;
  logic [7:0] cnt_next;
  logic       at_limit;

  assign acc0     = (state == OWN0) & m0_req & m0_grant;
  assign acc1     = (state == OWN1) & m1_req & m1_grant;
  assign cnt_next = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 8'd1;
  assign at_limit = (cnt_next == HOLD_LIM);

  // Grant is the state delayed by one cycle, so a newly chosen owner sees
  // its grant one cycle after the decision and a departing owner keeps it
  // through the first IDLE cycle, which forces the turnaround gap.
  always_ff @(posedge lb_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= 8'd0;
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
    end else begin
      m0_grant <= (state == OWN0);
      m1_grant <= (state == OWN1);
      case (state)
        IDLE: begin
          if (m0_req && (!m1_req || last_owner)) state <= OWN0;
          else if (m1_req)                       state <= OWN1;
        end
        OWN0: begin
          if (!m0_req || (acc0 && at_limit && m1_req)) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            hold_cnt   <= 8'd0;
          end else if (acc0) begin
            hold_cnt <= cnt_next;
          end
        end
        OWN1: begin
          if (!m1_req || (acc1 && at_limit && m0_req)) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= 8'd0;
          end else if (acc1) begin
            hold_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command issue: address/data hold their last value when idle.
  always_ff @(posedge lb_clk or negedge rstn) begin
    if (!rstn) begin
      lb_strobe   <= 1'b0;
      lb_rd       <= 1'b0;
      lb_write    <= 1'b0;
      lb_addr     <= '0;
      lb_data_out <= '0;
      lb_owner    <= 1'b0;
    end else begin
      lb_strobe <= acc0 | acc1;
      if (acc0) begin
        lb_rd       <= m0_rd;
        lb_write    <= m0_write;
        lb_addr     <= m0_addr;
        lb_data_out <= m0_wdata;
        lb_owner    <= 1'b0;
      end else if (acc1) begin
        lb_rd       <= m1_rd;
        lb_write    <= m1_write;
        lb_addr     <= m1_addr;
        lb_data_out <= m1_wdata;
        lb_owner    <= 1'b1;
      end else begin
        lb_rd    <= 1'b0;
        lb_write <= 1'b0;
      end
    end
  end

  // Stage READ_LAT-1 lines up with valid lb_din for the read it tags.
  always_ff @(posedge lb_clk or negedge rstn) begin
    if (!rstn) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= lb_strobe & lb_rd;
      tag_o[0] <= lb_owner;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign m0_rd_valid = tag_v[READ_LAT-1] & ~tag_o[READ_LAT-1];
  assign m1_rd_valid = tag_v[READ_LAT-1] &  tag_o[READ_LAT-1];
  assign m0_rdata    = lb_din;
  assign m1_rdata    = lb_din;

`ifdef LB_ARBITER_STATS_EN
  logic contend;
  assign contend = (m0_req & ~m0_grant) | (m1_req & ~m1_grant);

  always_ff @(posedge lb_clk or negedge rstn) begin
    if (!rstn) begin
      m0_xfer_cnt <= 16'd0;
      m1_xfer_cnt <= 16'd0;
      contend_cnt <= 16'd0;
    end else if (stats_clr) begin
      m0_xfer_cnt <= 16'd0;
      m1_xfer_cnt <= 16'd0;
      contend_cnt <= 16'd0;
    end else begin
      if (acc0 && m0_xfer_cnt != 16'hFFFF) m0_xfer_cnt <= m0_xfer_cnt + 16'd1;
      if (acc1 && m1_xfer_cnt != 16'hFFFF) m1_xfer_cnt <= m1_xfer_cnt + 16'd1;
      if (contend && contend_cnt != 16'hFFFF) contend_cnt <= contend_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
